// File: rtl/display_scan_ctrl_pkg.sv
// Shared types and defaults for the multiplexed status-display scanner.
package display_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        BLANK  = 2'd2
    } scan_state_t;

    localparam int DEF_NUM_DIGITS   = 4;
    localparam int DEF_DATA_W       = 2;
    localparam int DEF_ON_CYC       = 1000;
    localparam int DEF_BLANK_CYC    = 16;
    localparam int DEF_BLINK_FRAMES = 32;

    // Bits needed to hold 0..n-1; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/display_scan_ctrl_if.sv
// Frame-load handshake plus the scanned digit pins, with the scan state for observation.
interface display_scan_ctrl_if
    import display_pkg::*;
#(
    parameter int NUM_DIGITS = DEF_NUM_DIGITS,
    parameter int DATA_W     = DEF_DATA_W
) ();

    localparam int IDX_W = idx_width(NUM_DIGITS);

    // Frame handshake: the producer holds frame_data/blink_mask stable while
    // frame_valid is high; a frame transfers on any rising edge where
    // frame_valid && frame_ready, and frame_ready never depends on frame_valid.
    logic                         enable;
    logic [NUM_DIGITS*DATA_W-1:0] frame_data;
    logic [NUM_DIGITS-1:0]        blink_mask;
    logic                         frame_valid;
    logic                         frame_ready;

    logic [NUM_DIGITS-1:0]        digit_sel_n;
    logic [DATA_W-1:0]            digit_data;
    logic [IDX_W-1:0]             digit_idx;
    logic                         frame_start;
    scan_state_t                  scan_state;

    modport master (
        output enable, frame_data, blink_mask, frame_valid,
        input  frame_ready, digit_sel_n, digit_data, digit_idx, frame_start, scan_state
    );

    modport slave (
        input  enable, frame_data, blink_mask, frame_valid,
        output frame_ready, digit_sel_n, digit_data, digit_idx, frame_start, scan_state
    );

endinterface

// File: rtl/display_scan_ctrl_slot_timer.sv
// Loadable down-counter timing the lit and blanked parts of each digit slot.
module slot_timer
    import display_pkg::*;
#(
    parameter int ON_CYC    = DEF_ON_CYC,
    parameter int BLANK_CYC = DEF_BLANK_CYC
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear_i,
    input  logic load_on_i,
    input  logic load_blank_i,
    input  logic active_i,
    input  logic blank_i,
    output logic on_done_o,
    output logic blank_done_o
);

    localparam int MAX_CYC = (ON_CYC > BLANK_CYC) ? ON_CYC : BLANK_CYC;
    localparam int CNT_W   = idx_width(MAX_CYC);
    localparam logic [CNT_W-1:0] ON_LOAD    = CNT_W'(ON_CYC - 1);
    localparam logic [CNT_W-1:0] BLANK_LOAD = (BLANK_CYC > 0) ? CNT_W'(BLANK_CYC - 1) : '0;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Loaded with length-1 on entry, so the strobe fires in the last cycle of the window.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (load_on_i) begin
            cnt_d = ON_LOAD;
        end else if (load_blank_i) begin
            cnt_d = BLANK_LOAD;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign on_done_o    = active_i && (cnt_q == '0);
    assign blank_done_o = blank_i  && (cnt_q == '0);

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed digit scanner with double-buffered frame load and per-digit blink.
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int NUM_DIGITS   = DEF_NUM_DIGITS,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int ON_CYC       = DEF_ON_CYC,
    parameter int BLANK_CYC    = DEF_BLANK_CYC,
    parameter int BLINK_FRAMES = DEF_BLINK_FRAMES
) (
    input  logic                 clock,
    input  logic                 reset_n,
    display_scan_ctrl_if.slave   bus
);

    localparam int IDX_W = idx_width(NUM_DIGITS);
    localparam int BF_W  = idx_width(BLINK_FRAMES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [BF_W-1:0]  BF_LAST  = BF_W'(BLINK_FRAMES - 1);

    scan_state_t state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d, next_idx;

    logic [NUM_DIGITS-1:0][DATA_W-1:0] shadow_data_q, shadow_data_d;
    logic [NUM_DIGITS-1:0]             shadow_mask_q, shadow_mask_d;
    logic [NUM_DIGITS-1:0][DATA_W-1:0] pend_data_q, pend_data_d;
    logic [NUM_DIGITS-1:0]             pend_mask_q, pend_mask_d;
    logic                              pend_full_q, pend_full_d;

    logic [BF_W-1:0] blink_cnt_q, blink_cnt_d;
    logic            blink_phase_q, blink_phase_d;

    logic [NUM_DIGITS-1:0] sel_n_q, sel_n_d;
    logic [DATA_W-1:0]     data_q, data_d;
    logic                  frame_start_q, frame_start_d;

    logic load_on, load_blank, clear_cnt, on_done, blank_done;
    logic boundary, accept;

    slot_timer #(
        .ON_CYC    (ON_CYC),
        .BLANK_CYC (BLANK_CYC)
    ) u_slot_timer (
        .clock        (clock),
        .reset_n      (reset_n),
        .clear_i      (clear_cnt),
        .load_on_i    (load_on),
        .load_blank_i (load_blank),
        .active_i     (state_q == ACTIVE),
        .blank_i      (state_q == BLANK),
        .on_done_o    (on_done),
        .blank_done_o (blank_done)
    );

    assign next_idx  = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
    assign clear_cnt = (state_d == IDLE);

    // Scan sequencing; boundary marks the exit from the last digit's slot.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        load_on    = 1'b0;
        load_blank = 1'b0;
        boundary   = 1'b0;
        if (!bus.enable) begin
            state_d = IDLE;
            idx_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = ACTIVE;
                    idx_d   = '0;
                    load_on = 1'b1;
                end
                ACTIVE: begin
                    if (on_done) begin
                        if (BLANK_CYC == 0) begin
                            boundary = (idx_q == LAST_IDX);
                            idx_d    = next_idx;
                            load_on  = 1'b1;
                        end else begin
                            state_d    = BLANK;
                            load_blank = 1'b1;
                        end
                    end
                end
                BLANK: begin
                    if (blank_done) begin
                        boundary = (idx_q == LAST_IDX);
                        idx_d    = next_idx;
                        state_d  = ACTIVE;
                        load_on  = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    idx_d   = '0;
                end
            endcase
        end
    end

    // Accept and transfer are mutually exclusive: accept needs an empty pending buffer.
    assign accept = bus.frame_valid && !pend_full_q;

    always_comb begin
        shadow_data_d = shadow_data_q;
        shadow_mask_d = shadow_mask_q;
        pend_data_d   = pend_data_q;
        pend_mask_d   = pend_mask_q;
        pend_full_d   = pend_full_q;
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        if (boundary && pend_full_q) begin
            shadow_data_d = pend_data_q;
            shadow_mask_d = pend_mask_q;
            pend_full_d   = 1'b0;
        end
        if (accept) begin
            pend_data_d = bus.frame_data;
            pend_mask_d = bus.blink_mask;
            pend_full_d = 1'b1;
        end
        if (boundary) begin
            if (blink_cnt_q == BF_LAST) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
    end

    // Pin values are built from next-state so every output leaves a flop.
    always_comb begin
        sel_n_d       = '1;
        data_d        = data_q;
        frame_start_d = 1'b0;
        if (state_d == ACTIVE) begin
            data_d        = shadow_data_d[idx_d];
            frame_start_d = load_on && (idx_d == '0);
            if (!(blink_phase_d && shadow_mask_d[idx_d])) begin
                sel_n_d[idx_d] = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            shadow_data_q <= '0;
            shadow_mask_q <= '0;
            pend_data_q   <= '0;
            pend_mask_q   <= '0;
            pend_full_q   <= 1'b0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            sel_n_q       <= '1;
            data_q        <= '0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            shadow_data_q <= shadow_data_d;
            shadow_mask_q <= shadow_mask_d;
            pend_data_q   <= pend_data_d;
            pend_mask_q   <= pend_mask_d;
            pend_full_q   <= pend_full_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            sel_n_q       <= sel_n_d;
            data_q        <= data_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign bus.frame_ready = ~pend_full_q;
    assign bus.digit_sel_n = sel_n_q;
    assign bus.digit_data  = data_q;
    assign bus.digit_idx   = idx_q;
    assign bus.frame_start = frame_start_q;
    assign bus.scan_state  = state_q;

endmodule
